// File: rtl/fifo_wr_arbiter.sv
// Burst round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// Optional `FIFO_ARB_STATS_EN adds a saturating stall_cycles counter output.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 8,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clock_in,
  input  logic                          rst_in_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          data_in_valid,
  input  logic                          data_in_full,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          grant_active
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]                   stall_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [IDX_W-1:0]      g_inc;
  logic [IDX_W-1:0]      pick_base;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  logic                  v_g;
  logic                  xfer;
  logic                  last_word;
  logic                  release_g;
  logic [DATA_WIDTH-1:0] data_sel;

  // Successor of the granted index, wrapping at NUM_REQ.
  always_comb begin
    g_inc = grant_id_q + IDX_W'(1);
    if (grant_id_q == IDX_W'(NUM_REQ - 1)) begin
      g_inc = '0;
    end
  end

  // Round-robin search: first valid requester from pick_base, wrapping.
  always_comb begin
    logic [IDX_W:0] k;
    pick_base  = (state_q == S_IDLE) ? rr_ptr_q : g_inc;
    pick_found = 1'b0;
    pick_idx   = '0;
    k          = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = {1'b0, pick_base} + (IDX_W + 1)'(i);
      if (k >= (IDX_W + 1)'(NUM_REQ)) begin
        k = k - (IDX_W + 1)'(NUM_REQ);
      end
      if (req_valid[k[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = k[IDX_W-1:0];
      end
    end
  end

  // Word mux and transfer/release qualifiers for the current grant.
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDX_W'(i)) begin
        data_sel = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    v_g       = req_valid[grant_id_q];
    xfer      = v_g && !data_in_full;
    last_word = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
    release_g = !v_g || (xfer && last_word);
  end

  // Next-state: arbitrate from IDLE, count and rotate bursts in GRANT.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d     = S_GRANT;
          grant_id_d  = pick_idx;
          burst_cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (release_g) begin
          rr_ptr_d    = g_inc;
          burst_cnt_d = '0;
          if (pick_found) begin
            grant_id_d = pick_idx;
          end else begin
            state_d = S_IDLE;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock_in) begin
    if (!rst_in_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Outputs; handshakes are forced low while reset is asserted.
  always_comb begin
    logic act;
    act           = rst_in_n && (state_q == S_GRANT);
    grant_active  = act;
    grant_id      = grant_id_q;
    data_in       = act ? data_sel : '0;
    data_in_valid = act && v_g;
    req_ready     = '0;
    if (act && !data_in_full) begin
      req_ready[grant_id_q] = 1'b1;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles the fifo refuses an offered word.
  always_comb begin
    stall_d = stall_q;
    if (data_in_valid && data_in_full && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register, cleared by reset.
  always_ff @(posedge clock_in) begin
    if (!rst_in_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the write side of one fifo instance among NUM_REQ producers in the clock_in domain. Each grant is burst-based and lasts up to MAX_BURST words. Producers use a valid/ready handshake. The fifo side is driven with the fifo's native data_in / data_in_valid / data_in_full semantics. The block sits directly in front of the fifo's write port and shares its clock and reset.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
DATA_WIDTH, 32, word width; equals fifo DATA_WIDTH
MAX_BURST, 8, max words per grant before rotation (>=1)

Ports:
clock_in  input  1  write-domain clock
rst_in_n  input  1  synchronous reset, active-low
req_data  input  NUM_REQ*DATA_WIDTH  packed requester words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_valid  input  NUM_REQ  requester i has a word
req_ready  output  NUM_REQ  word of requester i accepted this cycle when req_valid[i] and req_ready[i] are both high
data_in  output  DATA_WIDTH  to fifo data_in
data_in_valid  output  1  to fifo data_in_valid
data_in_full  input  1  from fifo data_in_full
grant_id  output  IDX_W  current granted index, IDX_W = max(1,$clog2(NUM_REQ))
grant_active  output  1  high in GRANT state

Behaviour:
- Interface: one clock, clock_in; rst_in_n is synchronous, active-low.
- Reset (rst_in_n low at posedge): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0.
- While rst_in_n is low, data_in_valid, req_ready and grant_active are forced to 0 combinationally.
- Transfer condition: req_valid[g] && !data_in_full, where g=grant_id. This matches the fifo write rule, which accepts on posedge clock_in when valid && !full.
- State IDLE:
  - Outputs data_in_valid=0, req_ready=0, data_in=0.
  - If any req_valid is high, pick the first set index scanning rr_ptr, rr_ptr+1, ... with wrap mod NUM_REQ.
  - Next cycle: state=GRANT, grant_id=picked, burst_cnt=0. Arbitration latency is 1 cycle from IDLE.
- State GRANT:
  - data_in = req_data slice of g (combinational mux).
  - data_in_valid = req_valid[g].
  - req_ready[g] = !data_in_full; all other req_ready bits = 0.
  - data_in_valid has no combinational dependence on data_in_full. req_ready does depend on it combinationally.
- burst_cnt width is $clog2(MAX_BURST+1). It increments on each transfer and holds while data_in_full=1.
- Release occurs when either:
  - (a) a transfer happens with burst_cnt==MAX_BURST-1, or
  - (b) req_valid[g]==0 in GRANT, meaning end of packet. No transfer occurs that cycle.
- On release:
  - rr_ptr = (g+1) mod NUM_REQ.
  - Re-arbitrate in the same cycle from (g+1) with wrap. Requester g is eligible last, via its still-high valid in case (a).
  - If a winner exists: stay in GRANT, grant_id=winner, burst_cnt=0. There is no bubble between bursts.
  - If there is no winner: go to IDLE.
- Full stall: grant, data_in and burst_cnt all hold. There is no timeout.
- Valid dropping while full causes a release per (b).
- MAX_BURST=1 gives word-level round robin.
- NUM_REQ=1 gives a permanent owner with no bubble (case (a) re-grants index 0).
- Requesters need not hold valid. A dropped valid ends its grant.
- Reset mid-burst aborts the burst. The partial burst is not resumed and no word is duplicated or lost beyond the words already accepted.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined:
  - Adds output stall_cycles [15:0].
  - Increments each cycle where data_in_valid && data_in_full.
  - Saturates at 16'hFFFF and is cleared by reset.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_in_n=0 for 3 cycles, req_valid=4'b1111 -> data_in_valid=0, req_ready=0, grant_active=0 throughout. grant_id=0 and grant_active=1 one cycle after rst_in_n=1.
- All 4 continuously valid, full=0, requester i sends i*256+n -> bursts of 8 words in grant order 0,1,2,3,0. One word per cycle, no bubbles. Fifo sequence = 0..7, 256..263, 512..519, 768..775, 8..15.
- Only req 2 valid for 20 words -> 20 consecutive transfers with grant_id=2. burst_cnt wraps 0..7 twice, then 0..3. No idle cycles.
- Req1 granted and 3 words done; full=1 for 5 cycles; req2 also valid -> req_ready[1]=0, grant_id=1 and burst_cnt=3 held for 5 cycles. Then 5 more words from req1, then grant moves to req2 (bubble-free).
- Req1 drops valid after 2 words while req3 valid -> release that cycle. Next cycle grant_id=3, data_in_valid=1, burst_cnt=0.
- With FIFO_ARB_STATS_EN: full=1 for 10 cycles during a grant -> stall_cycles=10; a reset mid-burst then gives stall_cycles=0, state IDLE, rr_ptr=0.
